// File: rtl/divisor_sequencial_if.sv
// divisor_sequencial_if: start/operand/result bundle between control unit and divider
interface divisor_sequencial_if #(
    parameter int LARGURA = 32
);
    logic               start;
    logic [LARGURA-1:0] dividendo;
    logic [LARGURA-1:0] divisor;
    logic               busy;
    logic               done;
    logic [LARGURA-1:0] quociente;
    logic [LARGURA-1:0] resto;
    logic               div_zero;
    modport master (
        output start, dividendo, divisor,
        input  busy, done, quociente, resto, div_zero
    );
    modport slave (
        input  start, dividendo, divisor,
        output busy, done, quociente, resto, div_zero
    );
endinterface

// File: rtl/divisor_sequencial.sv
// divisor_sequencial: multi-cycle unsigned shift-and-subtract divider, one quotient bit per cycle
module divisor_sequencial #(
    parameter int LARGURA = 32
) (
    input logic                 clock,
    input logic                 reset,
    divisor_sequencial_if.slave bus
);
    localparam int CW = $clog2(LARGURA) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);
    typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;
    estado_t            state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LARGURA-1:0] q_q, q_d, r_q, r_d, dvs_q, dvs_d, quo_q, quo_d, res_q, res_d;
    logic [LARGURA-1:0] q_nxt, r_nxt;
    logic [LARGURA:0]   t;
    logic               dz_q, dz_d, aceita, ge;
    assign aceita = bus.start && state_q != CALC;
    // all state, cleared by the active-low synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= OCIOSO;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end
    // next state: a zero divisor skips CALC, the last step lands in FIM, start ignored in CALC
    always_comb begin
        state_d = state_q == CALC ? (cnt_q == ULTIMO ? FIM : CALC)
                : aceita          ? (bus.divisor == '0 ? FIM : CALC)
                :                   OCIOSO;
    end
    // datapath: operand capture on accept, one restoring step per CALC cycle, results on the last step
    always_comb begin
        t     = {r_q, q_q[LARGURA-1]};
        ge    = t >= {1'b0, dvs_q};
        r_nxt = ge ? LARGURA'(t - {1'b0, dvs_q}) : t[LARGURA-1:0];
        q_nxt = {q_q[LARGURA-2:0], ge};
        cnt_d = cnt_q;
        q_d   = q_q;
        r_d   = r_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        res_d = res_q;
        dz_d  = dz_q;
        if (state_q == CALC) begin
            cnt_d = cnt_q + CW'(1);
            q_d   = q_nxt;
            r_d   = r_nxt;
            if (cnt_q == ULTIMO) begin
                quo_d = q_nxt;
                res_d = r_nxt;
                dz_d  = 1'b0;
            end
        end else if (aceita) begin
            if (bus.divisor != '0) begin
                dvs_d = bus.divisor;
                q_d   = bus.dividendo;
                r_d   = '0;
                cnt_d = '0;
            end else begin
                quo_d = '1;
                res_d = bus.dividendo;
                dz_d  = 1'b1;
            end
        end
    end
    // outputs: busy during CALC, done during the single FIM cycle
    always_comb begin
        bus.busy      = state_q == CALC;
        bus.done      = state_q == FIM;
        bus.quociente = quo_q;
        bus.resto     = res_q;
        bus.div_zero  = dz_q;
    end
endmodule

// File: tb/tb_divisor_sequencial.sv
// tb_divisor_sequencial: directed and random checks of the sequential divider
module tb_divisor_sequencial;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clock = ~clock;
    divisor_sequencial_if #(.LARGURA(32)) bus ();
    divisor_sequencial #(.LARGURA(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic div_op(input logic [31:0] a, input logic [31:0] b);
        int          lat;
        bit          busy_seen;
        logic [31:0] eq, er;
        eq = b == 0 ? 32'hFFFF_FFFF : a / b;
        er = b == 0 ? a : a % b;
        @(negedge clock);
        bus.start = 1'b1;
        bus.dividendo = a;
        bus.divisor = b;
        @(negedge clock);
        bus.start = 1'b0;
        bus.dividendo = $urandom;
        bus.divisor = $urandom;
        lat = 1;
        busy_seen = 1'b0;
        while (!bus.done && lat < 60) begin
            busy_seen |= bus.busy;
            @(negedge clock);
            lat++;
        end
        chk("latencia", lat, b == 0 ? 1 : 33);
        chk("quociente", bus.quociente, eq);
        chk("resto", bus.resto, er);
        chk("div_zero", bus.div_zero, b == 0);
        chk("busy_visto", busy_seen, b != 0);
        chk("busy_com_done", bus.busy, 0);
        @(negedge clock);
        chk("done_pulso", bus.done, 0);
        chk("quociente_mantido", bus.quociente, eq);
    endtask

    initial begin
        int          ndone, dlat, lat;
        logic [31:0] dq, dr;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        bus.start = 1'b0;
        bus.dividendo = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quociente", bus.quociente, 0);
        chk("rst_resto", bus.resto, 0);
        chk("rst_div_zero", bus.div_zero, 0);
        reset = 1'b1;
        div_op(100, 7);
        div_op(32'hFFFF_FFFF, 1);
        div_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        div_op(5, 9);
        div_op(0, 3);
        div_op(1234, 0);
        chk("dz_quociente", bus.quociente, 32'hFFFF_FFFF);
        chk("dz_resto", bus.resto, 1234);
        // start while busy is ignored
        @(negedge clock);
        bus.start = 1'b1;
        bus.dividendo = 100;
        bus.divisor = 7;
        @(negedge clock);
        bus.start = 1'b0;
        ndone = 0;
        dlat = 0;
        dq = '0;
        dr = '0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                bus.start = 1'b1;
                bus.dividendo = 50;
                bus.divisor = 5;
            end
            if (i == 11) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                dlat = i;
                dq = bus.quociente;
                dr = bus.resto;
            end
            @(negedge clock);
        end
        chk("ocupado_ndone", ndone, 1);
        chk("ocupado_latencia", dlat, 33);
        chk("ocupado_quociente", dq, 14);
        chk("ocupado_resto", dr, 2);
        // reset in the middle of CALC
        @(negedge clock);
        bus.start = 1'b1;
        bus.dividendo = 100;
        bus.divisor = 7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        chk("meio_busy_antes", bus.busy, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("meio_busy", bus.busy, 0);
        chk("meio_done", bus.done, 0);
        chk("meio_quociente", bus.quociente, 0);
        chk("meio_resto", bus.resto, 0);
        chk("meio_div_zero", bus.div_zero, 0);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge clock);
        end
        chk("meio_sem_done", ndone, 0);
        div_op(81, 9);
        // back-to-back with start held high
        va = '{32'd1000, 32'd77, 32'hDEAD_BEEF, 32'd12};
        vb = '{32'd10, 32'd7, 32'h0000_1234, 32'd5};
        @(negedge clock);
        bus.start = 1'b1;
        bus.dividendo = va[0];
        bus.divisor = vb[0];
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            while (!bus.done && lat < 60) begin
                @(negedge clock);
                lat++;
            end
            chk("b2b_periodo", lat, 33);
            chk("b2b_quociente", bus.quociente, va[k] / vb[k]);
            chk("b2b_resto", bus.resto, va[k] % vb[k]);
            if (k < 3) begin
                bus.dividendo = va[k+1];
                bus.divisor = vb[k+1];
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
            lat = 1;
            chk("b2b_busy", bus.busy, k < 3);
            chk("b2b_done", bus.done, 0);
        end
        // random operands against / and %
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            div_op(a, b);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/divisor_sequencial.md
# divisor_sequencial

Multi-cycle unsigned integer divider for the MIPS core: the iterative counterpart of the combinational adder, computing the quotient and remainder by repeated shift-and-subtract instead of a single add. The control unit launches it for DIVU, stalls the PC while `busy` is high, and writes `quociente` to LO and `resto` to HI when `done` pulses. Operands are captured once per operation, so the datapath may change them freely while the division is running.

## Interface
- `LARGURA`, default 32: operand and result width in bits. The iteration counter is $clog2(LARGURA)+1 bits wide.
- `clock`, input, 1: single clock for the block; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `start`, input, 1: request a division; sampled on the rising edge.
- `dividendo`, input, LARGURA: unsigned dividend; captured on the accepting edge.
- `divisor`, input, LARGURA: unsigned divisor; captured on the accepting edge.
- `busy`, output, 1: high while a division is in progress.
- `done`, output, 1: one-cycle pulse; results are valid while it is high.
- `quociente`, output, LARGURA: quotient, registered; goes to LO.
- `resto`, output, LARGURA: remainder, registered; goes to HI.
- `div_zero`, output, 1: high with `done` when the captured divisor was 0; held with the results.

## Operation
- State machine `OCIOSO` → `CALC` → `FIM`.
  - `OCIOSO`: idle.
  - `CALC`: one quotient bit per cycle.
  - `FIM`: `done` is high.
- Reset (`reset`=0 on an edge), from any state including mid-`CALC`:
  - State goes to `OCIOSO`; the counter is cleared.
  - `busy`=0, `done`=0, `div_zero`=0, `quociente`=0, `resto`=0.
  - Any operation in progress is abandoned without a `done` pulse.
- `start` is accepted only in `OCIOSO` or `FIM`. It is ignored in `CALC`: no restart, captured operands unchanged.
- On an accepting edge with `divisor`≠0:
  - Latch the divisor.
  - Load the shift register Q with `dividendo` and clear the partial remainder R (LARGURA+1 bits).
  - Clear the counter and go to `CALC`.
- On an accepting edge with `divisor`=0:
  - Skip `CALC` and go directly to `FIM`.
  - `quociente`={LARGURA{1'b1}}, `resto`=`dividendo`, `div_zero`=1.
- `CALC` step, one per edge:
  - T = {R[LARGURA-1:0], Q[LARGURA-1]}.
  - If T ≥ {1'b0, divisor}: R = T − divisor and Q = {Q[LARGURA-2:0], 1}.
  - Otherwise: R = T and Q = {Q[LARGURA-2:0], 0}.
  - The counter then increments.
  - The comparison and subtraction are unsigned, LARGURA+1 bits wide, so there is no overflow.
- After step LARGURA, the counter reaches LARGURA−1 before increment:
  - Load `quociente`=Q and `resto`=R[LARGURA-1:0].
  - `div_zero`=0; go to `FIM`.
- `FIM` lasts exactly one cycle; the next state is `OCIOSO`, or `CALC` if `start` is accepted that edge.
- `quociente`, `resto` and `div_zero` hold their values until the next accepted operation completes, or until reset.
- Invariant on normal completion: `dividendo` = `quociente`·`divisor` + `resto`, with `resto` < `divisor`.

## Timing
- Accepting edge E0: `busy` rises after E0, for a nonzero divisor.
- `CALC` occupies the LARGURA edges E1..E_LARGURA.
- After edge E_LARGURA: `done`=1 and `busy`=0, for exactly one cycle.
  - Latency from the `start` edge to the `done` cycle is LARGURA+1 cycles (33 at the default width).
- Divide by zero: `busy` never rises; `done`=1 in the cycle after E0 (latency 1).
- Back-to-back operation: `start`=1 during `FIM` is accepted.
  - `done` drops and `busy` rises in the next cycle.
  - The new operation completes LARGURA+1 cycles later.
  - Throughput is one division per LARGURA+1 cycles.
- `busy` and `done` are never high in the same cycle.
- `start` held high continuously restarts a new division each time `FIM` is reached; there is no level-sensitive lockup.

## Test plan
- **Basic division.** Reset, then `start` with 100/7 → `busy` for 32 cycles. `done` arrives 33 cycles after the start edge with `quociente`=14, `resto`=2, `div_zero`=0.
- **Extremes.** 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0. 0xFFFFFFFF/0xFFFFFFFF → q=1, r=0. 5/9 → q=0, r=5. 0/3 → q=0, r=0.
- **Divide by zero.** 1234/0 → `done` the next cycle with `div_zero`=1, q=0xFFFFFFFF, r=1234, and `busy` never high.
- **Start while busy.** Start 100/7, then pulse `start` with 50/5 at cycle 10 of `CALC`. Result is still q=14, r=2 at the original time, and exactly one `done` pulse occurs.
- **Reset mid-operation.** Assert `reset`=0 at cycle 15 of `CALC`. On the next edge all outputs are 0 and the state is `OCIOSO`, with no `done`. A fresh 81/9 then yields q=9, r=0.
- **Back-to-back and random.** Keep `start` high through `FIM` with new operands each time. Check correct results with periods of 33 cycles. Then run 1000 random operand pairs against a reference model using / and %.
